// File: rtl/seq_add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding,
// mode constants and the operand/chunk width legality check.
package seq_add_sub_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic bit chunking_legal(input int n, input int w);
    return (w >= 1) && (w <= n) && ((n % w) == 0);
  endfunction

endpackage

// File: rtl/seq_add_sub_csa.sv
// Conditional-sum adder slice: both carry-in outcomes are formed in
// parallel and the real carry-in only drives the final select.
module seq_add_sub_csa #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         ci_i,
  output logic [N-1:0] s_o,
  output logic         co_o
);

  logic [N:0] sum0_s;
  logic [N:0] sum1_s;

  // Precompute both candidate sums, then select on the incoming carry.
  always_comb begin
    sum0_s = {1'b0, a_i} + {1'b0, b_i};
    sum1_s = sum0_s + {{N{1'b0}}, 1'b1};
    if (ci_i) begin
      s_o  = sum1_s[N-1:0];
      co_o = sum1_s[N];
    end else begin
      s_o  = sum0_s[N-1:0];
      co_o = sum0_s[N];
    end
  end

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle N-bit add/subtract, W bits per clock through one shared slice,
// with start/busy/done handshake and registered sum/co/ovf.
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         ovf
);

  localparam int CHUNKS = N / W;
  localparam int KW     = $clog2(CHUNKS) + 1;
  localparam logic [KW-1:0] K_LAST     = KW'(CHUNKS - 1);
  localparam logic [N-1:0]  CHUNK_MASK = N'({W{1'b1}});

  generate
    if (!chunking_legal(N, W)) begin : g_illegal_chunking
      $error("seq_add_sub: N must be a non-zero multiple of W with 1 <= W <= N");
    end
  endgenerate

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res_q;
  logic          carry_q;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  sum_q;
  logic          co_q;
  logic          ovf_q;

  logic [31:0]   base_s;
  logic [W-1:0]  a_chunk_s;
  logic [W-1:0]  b_chunk_s;
  logic [W-1:0]  slice_sum_s;
  logic          slice_co_s;
  logic [N-1:0]  res_d;

  // Select the active chunk and merge the slice result into the running result.
  always_comb begin
    base_s    = 32'(k_q) * 32'(W);
    a_chunk_s = W'(a_q >> base_s);
    b_chunk_s = W'(b_q >> base_s);
    res_d     = (res_q & ~(CHUNK_MASK << base_s)) | (N'(slice_sum_s) << base_s);
  end

  seq_add_sub_csa #(.N(W)) u_csa (
    .a_i  (a_chunk_s),
    .b_i  (b_chunk_s),
    .ci_i (carry_q),
    .s_o  (slice_sum_s),
    .co_o (slice_co_s)
  );

  // Control FSM, operand/carry latches and registered result outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      k_q     <= {KW{1'b0}};
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      res_q   <= {N{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {N{1'b0}};
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= (sub == MODE_SUB) ? ~b : b;
            carry_q <= (sub == MODE_SUB) ? 1'b1 : ci;
            k_q     <= {KW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q   <= res_d;
          carry_q <= slice_co_s;
          if (k_q == K_LAST) begin
            // b_q already holds the inverted operand in subtract mode.
            sum_q   <= res_d;
            co_q    <= slice_co_s;
            ovf_q   <= (a_q[N-1] == b_q[N-1]) && (res_d[N-1] != a_q[N-1]);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            k_q     <= {KW{1'b0}};
            state_q <= ST_IDLE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          k_q     <= {KW{1'b0}};
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench for seq_add_sub: directed N=16/W=4 vectors plus random
// sweeps on (16,1), (16,16) and (8,2) against a full-width reference.
module tb_seq_add_sub;

  typedef struct packed {
    logic [15:0] sum;
    logic        co;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  // main DUT (16,4)
  logic        start = 1'b0, sub = 1'b0, ci = 1'b0;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic        busy, done, co, ovf;
  logic [15:0] sum;

  seq_add_sub #(.N(16), .W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .co(co), .ovf(ovf)
  );

  // sweep DUTs share one stimulus bus
  logic        sw_start = 1'b0, sw_sub = 1'b0, sw_ci = 1'b0;
  logic [15:0] sw_a = 16'h0, sw_b = 16'h0;
  logic        w1_busy, w1_done, w1_co, w1_ovf;
  logic [15:0] w1_sum;
  logic        w16_busy, w16_done, w16_co, w16_ovf;
  logic [15:0] w16_sum;
  logic        n8_busy, n8_done, n8_co, n8_ovf;
  logic [7:0]  n8_sum;

  seq_add_sub #(.N(16), .W(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .start(sw_start), .sub(sw_sub), .a(sw_a), .b(sw_b), .ci(sw_ci),
    .busy(w1_busy), .done(w1_done), .sum(w1_sum), .co(w1_co), .ovf(w1_ovf)
  );
  seq_add_sub #(.N(16), .W(16)) u_w16 (
    .clk(clk), .reset_n(reset_n), .start(sw_start), .sub(sw_sub), .a(sw_a), .b(sw_b), .ci(sw_ci),
    .busy(w16_busy), .done(w16_done), .sum(w16_sum), .co(w16_co), .ovf(w16_ovf)
  );
  seq_add_sub #(.N(8), .W(2)) u_n8 (
    .clk(clk), .reset_n(reset_n), .start(sw_start), .sub(sw_sub), .a(sw_a[7:0]), .b(sw_b[7:0]), .ci(sw_ci),
    .busy(n8_busy), .done(n8_done), .sum(n8_sum), .co(n8_co), .ovf(n8_ovf)
  );

  exp_t q_main[$], q_w1[$], q_w16[$], q_n8[$];
  exp_t e_main, e_w1, e_w16, e_n8;

  task automatic cmp(input string nm, input logic [15:0] gs, input logic gco, input logic govf, input exp_t e);
    n_vec++;
    if (gs !== e.sum || gco !== e.co || govf !== e.ovf || cyc != e.cyc) begin
      n_fail++;
      $display("FAIL %s: got sum=%h co=%b ovf=%b cycle=%0d, expected sum=%h co=%b ovf=%b cycle=%0d",
               nm, gs, gco, govf, cyc, e.sum, e.co, e.ovf, e.cyc);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  task automatic unexpected(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s: done pulse with no pending operation (cycle %0d)", nm, cyc);
  endtask

  // Monitors: pop and compare on every done pulse.
  always @(negedge clk) if (done) begin
    if (q_main.size() == 0) unexpected("main_done");
    else begin e_main = q_main.pop_front(); cmp("main", sum, co, ovf, e_main); end
  end
  always @(negedge clk) if (w1_done) begin
    if (q_w1.size() == 0) unexpected("w1_done");
    else begin e_w1 = q_w1.pop_front(); cmp("n16w1", w1_sum, w1_co, w1_ovf, e_w1); end
  end
  always @(negedge clk) if (w16_done) begin
    if (q_w16.size() == 0) unexpected("w16_done");
    else begin e_w16 = q_w16.pop_front(); cmp("n16w16", w16_sum, w16_co, w16_ovf, e_w16); end
  end
  always @(negedge clk) if (n8_done) begin
    if (q_n8.size() == 0) unexpected("n8_done");
    else begin e_n8 = q_n8.pop_front(); cmp("n8w2", {8'h00, n8_sum}, n8_co, n8_ovf, e_n8); end
  end

  // Full-width modular reference: n is 8 or 16.
  function automatic exp_t ref_op(input int n, input logic [15:0] ra, input logic [15:0] rb,
                                  input logic rci, input logic rsub, input int lat);
    exp_t        r;
    logic [15:0] m, aa, bb;
    logic [16:0] t;
    m  = (n == 16) ? 16'hFFFF : 16'h00FF;
    aa = ra & m;
    bb = (rsub ? ~rb : rb) & m;
    t  = {1'b0, aa} + {1'b0, bb} + {16'h0000, (rsub ? 1'b1 : rci)};
    r.sum = t[15:0] & m;
    r.co  = (n == 16) ? t[16] : t[8];
    r.ovf = (aa[n-1] == bb[n-1]) && (r.sum[n-1] != aa[n-1]);
    r.cyc = cyc + lat;
    return r;
  endfunction

  task automatic wait_idle(input int maxc);
    int i = 0;
    while (busy && i < maxc) begin @(negedge clk); i++; end
    if (busy) chk("main_idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one operation on the main DUT; called at a negedge, returns at the next negedge.
  task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vci, input logic vsub,
                       input logic [15:0] es, input logic eco, input logic eovf, input bit push);
    exp_t e;
    wait_idle(20);
    a = va; b = vb; ci = vci; sub = vsub; start = 1'b1;
    @(posedge clk); #1;
    e.sum = es; e.co = eco; e.ovf = eovf; e.cyc = cyc + 4;
    if (push) q_main.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; ci = ~vci; sub = ~vsub;
  endtask

  typedef struct packed {
    logic [15:0] a, b;
    logic        ci, sub;
    logic [15:0] s;
    logic        co, ovf;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV] = '{
    '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0},
    '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0}
  };

  initial begin
    int busy_cnt;
    int i;
    exp_t e;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_co_ovf", 32'({co, ovf}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // first op: busy must be high for exactly 4 sampled cycles
    issue(vecs[0].a, vecs[0].b, vecs[0].ci, vecs[0].sub, vecs[0].s, vecs[0].co, vecs[0].ovf, 1'b1);
    busy_cnt = 1;
    i = 0;
    while (!done && i < 10) begin
      @(negedge clk); i++;
      if (busy) busy_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd4);

    for (int v = 1; v < NV; v++)
      issue(vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].sub, vecs[v].s, vecs[v].co, vecs[v].ovf, 1'b1);
    wait_idle(20);

    // start pulsed during RUN cycle 2 is ignored
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(20);
    repeat (6) @(negedge clk);
    chk("ignored_start_idle", 32'(busy), 32'd0);

    // start held through done: second op accepted without a bubble
    a = 16'h0100; b = 16'h0200; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    e = '{16'h0300, 1'b0, 1'b0, cyc + 4};
    q_main.push_back(e);
    @(negedge clk);
    a = 16'h0F00; b = 16'h0001; sub = 1'b1;
    i = 0;
    while (!done && i < 10) begin @(negedge clk); i++; end
    chk("held_done_seen", 32'(done), 32'd1);
    chk("held_busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    e = '{16'h0EFF, 1'b1, 1'b0, cyc + 4};
    q_main.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("sum_hold", 32'(sum), 32'h0300);
      @(negedge clk);
    end
    wait_idle(20);

    // reset mid-run aborts; reset wins over a simultaneous start
    issue(16'h00AA, 16'h0011, 1'b0, 1'b0, 16'h00BB, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_co", 32'(co), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1; start = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_stays_idle", 32'(busy), 32'd0);
    issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    wait_idle(20);
    @(negedge clk);

    // parameter sweep on the side instances
    for (int v = 0; v < 1000; v++) begin
      sw_a = 16'($urandom); sw_b = 16'($urandom);
      sw_ci = 1'($urandom); sw_sub = 1'($urandom);
      if (v < 4) begin sw_a = 16'hFFFF; sw_b = (v[0]) ? 16'hFFFF : 16'h0001; end
      sw_start = 1'b1;
      @(posedge clk); #1;
      q_w1.push_back(ref_op(16, sw_a, sw_b, sw_ci, sw_sub, 16));
      q_w16.push_back(ref_op(16, sw_a, sw_b, sw_ci, sw_sub, 1));
      q_n8.push_back(ref_op(8, sw_a, sw_b, sw_ci, sw_sub, 4));
      @(negedge clk);
      sw_start = 1'b0;
      sw_a = ~sw_a; sw_b = ~sw_b; sw_ci = ~sw_ci; sw_sub = ~sw_sub;
      i = 0;
      while ((w1_busy || w16_busy || n8_busy) && i < 40) begin @(negedge clk); i++; end
      if (w1_busy || w16_busy || n8_busy) chk("sweep_timeout", 32'({w1_busy, w16_busy, n8_busy}), 32'd0);
    end
    repeat (3) @(negedge clk);

    chk("main_queue_empty", 32'(q_main.size()), 32'd0);
    chk("w1_queue_empty", 32'(q_w1.size()), 32'd0);
    chk("w16_queue_empty", 32'(q_w16.size()), 32'd0);
    chk("n8_queue_empty", 32'(q_n8.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_add_sub.md
# seq_add_sub

Multi-cycle, parametrised binary adder/subtractor for the stopwatch datapath. Operands of N bits are processed W bits per clock, starting at the least-significant chunk, through one shared W-bit conditional-sum adder slice. This trades latency for area when N is large. A start/busy/done handshake feeds the time-accumulation and lap-difference logic. The block adds a subtract mode, signed overflow detection and registered outputs.

## Interface

Parameters:
- N, default 16: operand width in bits. N must be a multiple of W; any other value is an elaboration error.
- W, default 4: chunk width in bits, processed once per cycle. W must satisfy 1 ≤ W ≤ N.
- CHUNKS, derived as N/W: number of RUN cycles per operation. Not user-overridable.

Ports:
- clk, in, 1: single clock. All logic is rising-edge.
- reset_n, in, 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- start, in, 1: operation request. Sampled only when busy=0.
- sub, in, 1: mode. 0 computes a+b+ci; 1 computes a−b, with ci ignored.
- a, in, N: operand A. Captured at the start accept.
- b, in, N: operand B. Captured at the start accept.
- ci, in, 1: carry-in. Used in add mode only.
- busy, out, 1: high while an operation is in progress.
- done, out, 1: one-cycle pulse when the result is valid.
- sum, out, N: result. Held until the next completion.
- co, out, 1: carry-out. In subtract mode this is the not-borrow (1 = no borrow).
- ovf, out, 1: two's-complement signed overflow.

## Operation

- States:
  - IDLE: busy=0.
  - RUN: busy=1, chunk index k = 0..CHUNKS−1.
- IDLE→RUN on a clock edge with start=1 and reset_n=1. The accept does the following:
  - Latch a.
  - Latch b' = sub ? ~b : b.
  - Set the carry register to sub ? 1 : ci.
  - Set k to 0.
- In RUN, chunk k is processed each cycle:
  - Add a[k·W+W−1 : k·W] + b'[same] + carry through the W-bit slice.
  - Store the W-bit slice result into the internal result register.
  - Load the slice carry-out into the carry register.
  - Increment k.
- RUN→IDLE at the edge that processes chunk CHUNKS−1. At that same edge:
  - sum ← full result.
  - co ← final carry.
  - ovf ← (a[N−1] == b'[N−1]) && (result[N−1] != a[N−1]).
  - done ← 1 for exactly one cycle.
- start while busy=1 is ignored. It is neither queued nor does it disturb the operation.
- start in the cycle where done=1 is accepted, because busy=0. Back-to-back operations have no bubble.
- Operands a, b, sub and ci may change freely after the accept; only the latched copies are used.
- sum, co and ovf change only at completion. They are stable between completions.
- Width rules: no sign extension; pure N-bit modular arithmetic.

## Timing

- Reset (reset_n=0 at an edge) forces the following, regardless of state:
  - busy=0, done=0, sum=0, co=0, ovf=0.
  - State IDLE, k=0.
- Reset mid-operation aborts the operation: no done pulse and no partial result on sum.
- Reset has priority over start in the same cycle.
- Latency, taking the accept edge as E0:
  - busy is high in the cycles following E0 through E(CHUNKS−1).
  - done, sum, co and ovf are valid in the cycle following edge E(CHUNKS). Example: N=16, W=4 gives done 4 cycles after the accept.
- Throughput: one operation per CHUNKS cycles.
- W=N (CHUNKS=1): busy is high for one cycle and done follows at E1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared include `adder_defs.vh` holds:
  - the state encodings (ST_IDLE, ST_RUN);
  - the mode constants (MODE_ADD=0, MODE_SUB=1);
  - the N%W legality-check macro, reused by other multi-cycle arithmetic blocks.
- The per-chunk adder is one instance of the team's existing conditional-sum adder module CSA with parameter N=W. It is the only sub-module; there is no per-chunk replication.
- The k counter is ceil(log2(CHUNKS))+1 bits wide and is local to the block.

## Test plan

All scenarios use N=16, W=4 unless stated.
- Basic add: a=0x1234, b=0x4321, ci=0, sub=0 → sum=0x5555, co=0, ovf=0; done pulses 4 cycles after the accept; busy is high for exactly 4 cycles.
- Carry and overflow:
  - 0xFFFF+0x0001, ci=0 → sum=0x0000, co=1, ovf=0.
  - 0x7FFF+0x0001 → sum=0x8000, co=0, ovf=1.
  - 0x0000+0x0000 with ci=1 → sum=0x0001.
- Subtract:
  - 0x0005−0x0007 → sum=0xFFFE, co=0, ovf=0.
  - 0x8000−0x0001 → sum=0x7FFF, co=1, ovf=1.
  - With ci=1 → result unchanged.
- Handshake:
  - start pulsed at RUN cycle 2 → ignored; the first result is unaffected.
  - start held through the done cycle → second operation accepted; second done 4 cycles later; sum holds the first result until then.
- Reset mid-run: reset_n=0 during RUN cycle 2 → next cycle busy=0, done=0, sum=0, co=0, ovf=0; no done pulse follows; a new start afterwards completes normally.
- Parameter sweep: 1000 random a/b/ci/sub vectors for each of (N,W) = (16,1), (16,16) and (8,2), compared against a behavioural reference → exact match of sum/co/ovf, with latency = N/W.
